// File: rtl/ui_pkg.sv
// ---------------------------------------------------------------------------
// ui_pkg
// Shared definitions for the peripheral-to-FT601 transmit path.
//   WORD_W      : width of one transmitted data word
//   BE_W        : number of byte enables per word
//   arb_state_t : arbiter FSM states (IDLE searches, GRANT pops a burst)
// ---------------------------------------------------------------------------
package ui_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin search: returns the first set bit of req,
// scanning upward from start and wrapping past N-1 back to 0.
//   req   in  N     : request vector
//   start in  ID_W  : index the search begins at (must be < N)
//   found out 1     : at least one request is set
//   idx   out ID_W  : index of the selected request (0 when none found)
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] start,
  output logic            found,
  output logic [ID_W-1:0] idx
);

  // Scan offsets from farthest to nearest so the nearest requester,
  // written last, wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      int unsigned pos;
      pos = (int'(start) + i) % N;
      if (req[pos]) begin
        found = 1'b1;
        idx   = ID_W'(pos);
      end
    end
  end

endmodule

// File: rtl/periph_tx_arbiter.sv
// ---------------------------------------------------------------------------
// periph_tx_arbiter
// Round-robin, burst-limited merge of NUM_PERIPH first-word-fall-through
// transmit FIFOs into one registered 32-bit word stream for the FT601
// controller.
//   clk                   in  1          : clock
//   rst                   in  1          : asynchronous active-high reset
//   periph_empty          in  NUM_PERIPH : per-FIFO empty flag
//   periph_rdata          in  NUM_PERIPH x 32 : FIFO head words
//   periph_rbe            in  NUM_PERIPH x 4  : FIFO head byte enables
//   periph_rd             out NUM_PERIPH : one-hot pop strobe (combinational)
//   data_o                out 32         : registered output word
//   be_o                  out 4          : registered byte enables
//   src_id_o              out ID_W       : source FIFO of data_o
//   periph_data_available out 1          : output register holds a word
//   read_periph_data      in  1          : consumer takes the word this cycle
// ---------------------------------------------------------------------------
module periph_tx_arbiter
  import ui_pkg::*;
#(
  parameter int NUM_PERIPH = 4,
  parameter int BURST_MAX  = 16,
  parameter int ID_W       = $clog2(NUM_PERIPH)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_PERIPH-1:0]              periph_empty,
  input  logic [NUM_PERIPH-1:0][WORD_W-1:0]  periph_rdata,
  input  logic [NUM_PERIPH-1:0][BE_W-1:0]    periph_rbe,
  output logic [NUM_PERIPH-1:0]              periph_rd,
  output logic [WORD_W-1:0]                  data_o,
  output logic [BE_W-1:0]                    be_o,
  output logic [ID_W-1:0]                    src_id_o,
  output logic                               periph_data_available,
  input  logic                               read_periph_data
);

  localparam int CNT_W = $clog2(BURST_MAX + 1);

  arb_state_t       state, state_nxt;
  logic [ID_W-1:0]  grant, grant_nxt;
  logic [ID_W-1:0]  rr_ptr, rr_ptr_nxt;
  logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;

  logic             pick_found;
  logic [ID_W-1:0]  pick_idx;
  logic             load_ok;
  logic             pop;
  logic [ID_W-1:0]  grant_inc;

  rr_pick #(
    .N    (NUM_PERIPH),
    .ID_W (ID_W)
  ) u_pick (
    .req   (~periph_empty),
    .start (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // The output register can accept a word when it is empty or is being
  // drained in this same cycle, which gives back-to-back replacement.
  assign load_ok = !periph_data_available || read_periph_data;
  assign pop     = (state == GRANT) && load_ok && !periph_empty[grant];

  // Next round-robin start, wrapping explicitly so non-power-of-two
  // peripheral counts never point past the last FIFO.
  assign grant_inc = (grant == ID_W'(NUM_PERIPH - 1)) ? '0 : grant + 1'b1;

  always_comb begin
    periph_rd = '0;
    if (pop) periph_rd[grant] = 1'b1;
  end

  // Next-state logic. A burst ends either on the pop that reaches
  // BURST_MAX or on any GRANT cycle where the granted FIFO is empty;
  // both hand priority to the peripheral after the current grant.
  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant;
    rr_ptr_nxt    = rr_ptr;
    burst_cnt_nxt = burst_cnt;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt     = GRANT;
          grant_nxt     = pick_idx;
          burst_cnt_nxt = '0;
        end
      end
      GRANT: begin
        if (periph_empty[grant]) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = grant_inc;
        end else if (pop) begin
          burst_cnt_nxt = burst_cnt + 1'b1;
          if (burst_cnt + 1'b1 == CNT_W'(BURST_MAX)) begin
            state_nxt  = IDLE;
            rr_ptr_nxt = grant_inc;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Arbitration state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      rr_ptr    <= rr_ptr_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  // Output register: a pop loads the granted head word; otherwise a read
  // empties the register. Reads while it is empty change nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_o                <= '0;
      be_o                  <= '0;
      src_id_o              <= '0;
      periph_data_available <= 1'b0;
    end else if (pop) begin
      data_o                <= periph_rdata[grant];
      be_o                  <= periph_rbe[grant];
      src_id_o              <= grant;
      periph_data_available <= 1'b1;
    end else if (read_periph_data) begin
      periph_data_available <= 1'b0;
    end
  end

endmodule

// File: tb/tb_periph_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_periph_tx_arbiter
// Bench for periph_tx_arbiter with four FWFT FIFO models. Scenario tasks
// load the FIFOs and push the word order they expect into a scoreboard;
// a monitor pops the scoreboard on every consumed output word.
// ---------------------------------------------------------------------------
module tb_periph_tx_arbiter;

  localparam int N  = 4;
  localparam int BM = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic [N-1:0]        periph_empty;
  logic [N-1:0][31:0]  periph_rdata;
  logic [N-1:0][3:0]   periph_rbe;
  logic [N-1:0]        periph_rd;
  logic [31:0]         data_o;
  logic [3:0]          be_o;
  logic [1:0]          src_id_o;
  logic                periph_data_available;
  logic                read_periph_data;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [1:0]  id;
    logic [3:0]  be;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q [$];
  logic [35:0] fifo_q [N][$];
  logic [N-1:0] pop_snap;

  periph_tx_arbiter #(
    .NUM_PERIPH (N),
    .BURST_MAX  (BM)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .periph_empty          (periph_empty),
    .periph_rdata          (periph_rdata),
    .periph_rbe            (periph_rbe),
    .periph_rd             (periph_rd),
    .data_o                (data_o),
    .be_o                  (be_o),
    .src_id_o              (src_id_o),
    .periph_data_available (periph_data_available),
    .read_periph_data      (read_periph_data)
  );

  always #5 clk = ~clk;

  // Drive FWFT flags and head words from the FIFO model contents.
  task automatic sync_fifo();
    for (int i = 0; i < N; i++) begin
      periph_empty[i] = (fifo_q[i].size() == 0);
      if (fifo_q[i].size() != 0) {periph_rbe[i], periph_rdata[i]} = fifo_q[i][0];
      else begin
        periph_rbe[i]   = '0;
        periph_rdata[i] = '0;
      end
    end
  endtask

  function automatic logic [35:0] mk(input int id, input int tag, input int idx);
    logic [3:0]  be;
    logic [31:0] d;
    be = 4'((idx + id) % 15 + 1);
    d  = {8'(id), 8'(tag), 16'(idx)};
    return {be, d};
  endfunction

  task automatic fifo_push(input int id, input logic [35:0] w);
    fifo_q[id].push_back(w);
    sync_fifo();
  endtask

  task automatic exp_push(input int id, input logic [35:0] w);
    exp_t e;
    e.id   = 2'(id);
    e.be   = w[35:32];
    e.data = w[31:0];
    exp_q.push_back(e);
  endtask

  // FIFO model: pop on the strobe seen at the edge, update just after it.
  always @(posedge clk) begin
    pop_snap = periph_rd;
    #1;
    for (int i = 0; i < N; i++)
      if (pop_snap[i] && fifo_q[i].size() != 0) void'(fifo_q[i].pop_front());
    sync_fifo();
  end

  // Monitor: pop guarantees every cycle, scoreboard on every consumed word.
  always @(negedge clk) begin
    exp_t e;
    #3;
    if (!rst) begin
      checks++;
      if ((periph_rd & periph_empty) !== '0) begin
        errors++;
        $display("[TB] FAIL pop_empty: periph_rd=%b periph_empty=%b required no overlap", periph_rd, periph_empty);
      end
      checks++;
      if (!$onehot0(periph_rd)) begin
        errors++;
        $display("[TB] FAIL pop_onehot: periph_rd=%b required at most one bit", periph_rd);
      end
      if (periph_data_available && read_periph_data) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL extra_word: got id=%0d data=%h with nothing expected", src_id_o, data_o);
        end else begin
          e = exp_q.pop_front();
          if ({src_id_o, be_o, data_o} !== e) begin
            errors++;
            $display("[TB] FAIL word: got id=%0d be=%h data=%h required id=%0d be=%h data=%h",
                     src_id_o, be_o, data_o, e.id, e.be, e.data);
          end
        end
      end
    end
  end

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_timeout: %0d words outstanding required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    rst = 1'b1;
    read_periph_data = 1'b0;
    sync_fifo();
    repeat (3) @(negedge clk);
    checks++;
    if ({data_o, be_o, src_id_o, periph_data_available, periph_rd} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: data=%h be=%h id=%0d avail=%b rd=%b required all 0",
               data_o, be_o, src_id_o, periph_data_available, periph_rd);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({periph_data_available, periph_rd} !== '0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: avail=%b rd=%b required 0", periph_data_available, periph_rd);
    end
  endtask

  task automatic test_burst_rotation();
    $display("[TB] test_burst_rotation");
    read_periph_data = 1'b1;
    for (int id = 0; id < N; id++)
      for (int k = 0; k < 20; k++) fifo_push(id, mk(id, 1, k));
    for (int id = 0; id < N; id++)
      for (int k = 0; k < BM; k++) exp_push(id, mk(id, 1, k));
    for (int id = 0; id < N; id++)
      for (int k = BM; k < 20; k++) exp_push(id, mk(id, 1, k));
    wait_drain(300);
  endtask

  task automatic test_single_source();
    logic [35:0] a;
    $display("[TB] test_single_source");
    @(negedge clk);
    read_periph_data = 1'b1;
    a = mk(2, 2, 0);
    for (int k = 0; k < 3; k++) begin
      fifo_push(2, mk(2, 2, k));
      exp_push(2, mk(2, 2, k));
    end
    @(negedge clk);
    checks++;
    if (periph_rd !== 4'b0100 || periph_data_available !== 1'b0) begin
      errors++;
      $display("[TB] FAIL first_pop: rd=%b avail=%b required rd=0100 avail=0", periph_rd, periph_data_available);
    end
    @(negedge clk);
    checks++;
    if (periph_data_available !== 1'b1 || data_o !== a[31:0] || src_id_o !== 2'd2) begin
      errors++;
      $display("[TB] FAIL first_word: avail=%b data=%h id=%0d required 1 %h 2",
               periph_data_available, data_o, src_id_o, a[31:0]);
    end
    wait_drain(50);
    checks++;
    if (periph_data_available !== 1'b0 || periph_rd !== '0) begin
      errors++;
      $display("[TB] FAIL single_idle: avail=%b rd=%b required 0 0", periph_data_available, periph_rd);
    end
  endtask

  task automatic test_wrap();
    $display("[TB] test_wrap");
    read_periph_data = 1'b1;
    for (int k = 0; k < 2; k++) begin
      fifo_push(3, mk(3, 3, k));
      fifo_push(0, mk(0, 3, k));
    end
    for (int k = 0; k < 2; k++) exp_push(3, mk(3, 3, k));
    for (int k = 0; k < 2; k++) exp_push(0, mk(0, 3, k));
    wait_drain(50);
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    int n = 0;
    $display("[TB] test_backpressure");
    read_periph_data = 1'b0;
    for (int k = 0; k < 4; k++) begin
      fifo_push(1, mk(1, 4, k));
      exp_push(1, mk(1, 4, k));
    end
    while (!periph_data_available && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (periph_data_available !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_valid_timeout: avail=%b required 1", periph_data_available);
    end
    held = data_o;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (data_o !== held || periph_rd !== '0) begin
        errors++;
        $display("[TB] FAIL bp_hold: data=%h rd=%b required %h 0000", data_o, periph_rd, held);
      end
    end
    read_periph_data = 1'b1;
    wait_drain(50);
  endtask

  task automatic test_empty_mid_burst();
    int n = 0;
    $display("[TB] test_empty_mid_burst");
    read_periph_data = 1'b1;
    for (int k = 0; k < 5; k++) begin
      fifo_push(1, mk(1, 5, k));
      exp_push(1, mk(1, 5, k));
    end
    while (fifo_q[1].size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (fifo_q[1].size() != 0) begin
      errors++;
      $display("[TB] FAIL emb_timeout: fifo1 holds %0d required 0", fifo_q[1].size());
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      fifo_push(2, mk(2, 6, k));
      fifo_push(1, mk(1, 6, k));
    end
    for (int k = 0; k < 2; k++) exp_push(2, mk(2, 6, k));
    for (int k = 0; k < 2; k++) exp_push(1, mk(1, 6, k));
    wait_drain(50);
  endtask

  task automatic test_reset_mid_burst();
    int n = 0;
    $display("[TB] test_reset_mid_burst");
    read_periph_data = 1'b1;
    for (int k = 0; k < 6; k++) begin
      fifo_push(1, mk(1, 7, k));
      exp_push(1, mk(1, 7, k));
    end
    while (exp_q.size() > 4 && n < 30) begin
      @(negedge clk);
      n++;
    end
    read_periph_data = 1'b0;
    @(negedge clk);
    checks++;
    if (periph_data_available !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rmb_valid: avail=%b required 1", periph_data_available);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({data_o, be_o, src_id_o, periph_data_available, periph_rd} !== '0) begin
      errors++;
      $display("[TB] FAIL rmb_reset_outputs: data=%h be=%h id=%0d avail=%b rd=%b required all 0",
               data_o, be_o, src_id_o, periph_data_available, periph_rd);
    end
    exp_q.delete();
    fifo_push(0, mk(0, 8, 0));
    fifo_push(2, mk(2, 8, 0));
    exp_push(0, mk(0, 8, 0));
    for (int k = 0; k < fifo_q[1].size(); k++) exp_push(1, fifo_q[1][k]);
    exp_push(2, mk(2, 8, 0));
    @(negedge clk);
    rst = 1'b0;
    read_periph_data = 1'b1;
    wait_drain(60);
  endtask

  initial begin
    for (int i = 0; i < N; i++) fifo_q[i].delete();
    test_reset();
    test_burst_rotation();
    test_single_source();
    test_wrap();
    test_backpressure();
    test_empty_mid_burst();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
